// File: rtl/writeback_skid_stage_if.sv
// writeback_skid_stage_if: memory-stage input and register-file output bundle of the writeback skid stage
interface writeback_skid_stage_if #(
  parameter int WORD_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic                  RegWriteM;
  logic [1:0]            ResultSrcM;
  logic [WORD_WIDTH-1:0] ALUResultM;
  logic [WORD_WIDTH-1:0] ReadDataM;
  logic [WORD_WIDTH-1:0] PCPlus4M;
  logic [RD_WIDTH-1:0]   RdM;
  logic                  out_valid;
  logic                  out_ready;
  logic                  RegWriteW;
  logic [RD_WIDTH-1:0]   RdW;
  logic [WORD_WIDTH-1:0] ResultW;
  logic [1:0]            occupancy;
  modport master (
    output in_valid, RegWriteM, ResultSrcM, ALUResultM, ReadDataM, PCPlus4M, RdM, out_ready,
    input  in_ready, out_valid, RegWriteW, RdW, ResultW, occupancy
  );
  modport slave (
    input  in_valid, RegWriteM, ResultSrcM, ALUResultM, ReadDataM, PCPlus4M, RdM, out_ready,
    output in_ready, out_valid, RegWriteW, RdW, ResultW, occupancy
  );
endinterface

// File: rtl/writeback_skid_stage.sv
// writeback_skid_stage: two-entry skid buffer between memory and writeback with registered in_ready
module writeback_skid_stage #(
  parameter int WORD_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 flush,
  writeback_skid_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic                  rw;
    logic [1:0]            src;
    logic [WORD_WIDTH-1:0] alu;
    logic [WORD_WIDTH-1:0] rdata;
    logic [WORD_WIDTH-1:0] pc4;
    logic [RD_WIDTH-1:0]   rd;
  } entry_t;
  state_t state_q, state_n;
  entry_t main_q, skid_q, in_e;
  logic   in_ready_q, in_fire, out_fire, out_valid;
  logic   load_main, load_skid, main_from_skid;
  assign in_e = '{rw: bus.RegWriteM && (bus.RdM != '0), src: bus.ResultSrcM, alu: bus.ALUResultM,
                  rdata: bus.ReadDataM, pc4: bus.PCPlus4M, rd: bus.RdM};
  assign out_valid     = state_q != EMPTY;
  assign in_fire       = bus.in_valid && in_ready_q;
  assign out_fire      = out_valid && bus.out_ready;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.RegWriteW = main_q.rw && out_valid;
  assign bus.RdW       = main_q.rd;
  assign bus.occupancy = state_q == FULL ? 2'd2 : state_q == ONE ? 2'd1 : 2'd0;
  // result mux reads only the head entry; encoding 11 yields zero
  always_comb
    bus.ResultW = main_q.src == 2'b00 ? main_q.alu :
                  main_q.src == 2'b01 ? main_q.rdata :
                  main_q.src == 2'b10 ? main_q.pc4 : '0;
  // next-state and load strobes; flush overrides everything and drops any same-cycle input
  always_comb begin
    state_n        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: if (in_fire) begin
        state_n   = ONE;
        load_main = 1'b1;
      end
      ONE: if (in_fire && out_fire) load_main = 1'b1;
      else if (in_fire) begin
        state_n   = FULL;
        load_skid = 1'b1;
      end else if (out_fire) state_n = EMPTY;
      FULL: if (out_fire) begin
        state_n        = ONE;
        main_from_skid = 1'b1;
      end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n        = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end
  // state, registered in_ready (follows next state so out_ready never reaches in_ready combinationally) and entry storage
  always_ff @(posedge clk)
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_n;
      in_ready_q <= state_n != FULL;
      if (load_main) main_q <= in_e;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_e;
    end
endmodule

// File: tb/tb_writeback_skid_stage.sv
// tb_writeback_skid_stage: directed and random stimulus checked against a queue model of the stage
module tb_writeback_skid_stage;
  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
  } exp_t;
  logic clk = 0, reset = 0, flush = 0;
  int   checks = 0, errors = 0;
  exp_t q[$];
  writeback_skid_stage_if #(.WORD_WIDTH(32), .RD_WIDTH(5)) bus ();
  writeback_skid_stage #(.WORD_WIDTH(32), .RD_WIDTH(5)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic exp_t expect_in();
    exp_t e;
    e.rw  = bus.RegWriteM && bus.RdM != 0;
    e.rd  = bus.RdM;
    e.res = bus.ResultSrcM == 0 ? bus.ALUResultM : bus.ResultSrcM == 1 ? bus.ReadDataM :
            bus.ResultSrcM == 2 ? bus.PCPlus4M : 32'h0;
    return e;
  endfunction
  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4, input logic [4:0] rd);
    bus.in_valid = v; bus.RegWriteM = rw; bus.ResultSrcM = src;
    bus.ALUResultM = alu; bus.ReadDataM = rdata; bus.PCPlus4M = pc4; bus.RdM = rd;
  endtask
  task automatic tick();
    logic inf, outf;
    exp_t e;
    inf  = bus.in_valid && q.size() < 2;
    outf = q.size() > 0 && bus.out_ready;
    e    = expect_in();
    @(posedge clk);
    #1;
    if (!reset || flush) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(e);
    end
    chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      chk("RegWriteW", 32'(bus.RegWriteW), 32'(q[0].rw));
      chk("RdW", 32'(bus.RdW), 32'(q[0].rd));
      chk("ResultW", bus.ResultW, q[0].res);
    end else chk("RegWriteW_idle", 32'(bus.RegWriteW), 32'h0);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.out_ready = 0;
    reset = 0;
    tick();
    chk("rst_ResultW", bus.ResultW, 32'h0);
    reset = 1;
    bus.out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 2'b00, 32'(i), 32'hdead, 32'hbeef, 5);
      tick();
      chk("stream_result", bus.ResultW, 32'(i));
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.out_ready = 0;
    drive(1, 1, 2'b01, 32'h1, 32'hAAAA_0000, 32'h2, 7);
    tick();
    drive(1, 1, 2'b10, 32'h3, 32'h4, 32'h104, 8);
    tick();
    chk("bp_occ", 32'(bus.occupancy), 32'd2);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1, 1, 2'b00, 32'hC, 32'h5, 32'h6, 9);
    tick();
    tick();
    bus.out_ready = 1;
    tick();
    chk("bp_first", bus.ResultW, 32'h104);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("bp_c", bus.ResultW, 32'hC);
    tick();
    drive(1, 1, 2'b00, 32'h11, 0, 0, 0);
    tick();
    chk("x0_valid", 32'(bus.out_valid), 32'd1);
    chk("x0_rw", 32'(bus.RegWriteW), 32'd0);
    drive(1, 1, 2'b00, 32'h12, 0, 0, 3);
    tick();
    chk("x3_rw", 32'(bus.RegWriteW), 32'd1);
    bus.out_ready = 0;
    drive(1, 1, 2'b00, 32'h21, 0, 0, 4);
    tick();
    tick();
    drive(1, 1, 2'b00, 32'h22, 0, 0, 4);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_occ", 32'(bus.occupancy), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 2'b01, 0, 32'h31, 0, 6);
    tick();
    tick();
    chk("pre_rst_occ", 32'(bus.occupancy), 32'd2);
    reset = 0;
    tick();
    reset = 1;
    chk("rst_ResultW_mid", bus.ResultW, 32'h0);
    chk("rst_in_ready_mid", 32'(bus.in_ready), 32'd1);
    drive(1, 1, 2'b11, 32'h41, 32'h42, 32'h43, 2);
    tick();
    chk("src11_result", bus.ResultW, 32'h0);
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
      bus.out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 40) == 0;
      reset = $urandom_range(0, 80) != 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_skid_stage.md
WRITEBACK_SKID_STAGE -- requirements
Module: writeback_skid_stage

Interface
REQ-001 Parameter WORD_WIDTH, default 32, SHALL set the width of ALU result, read-data, PC+4 and result datapaths.
REQ-002 Parameter RD_WIDTH, default 5, SHALL set the destination-register index width.
REQ-003 Ports SHALL be (clock and reset first):
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; asserted when 0, sampled on the clk rising edge.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream (memory stage) entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- RegWriteM  in  1  register-file write enable.
- ResultSrcM  in  2  result select.
- ALUResultM, ReadDataM, PCPlus4M  in  WORD_WIDTH each  candidate results.
- RdM  in  RD_WIDTH  destination register.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream (register file) consumes head.
- RegWriteW  out  1  head write enable, already qualified.
- RdW  out  RD_WIDTH  head destination.
- ResultW  out  WORD_WIDTH  head selected result.
- occupancy  out  2  entries held, 0..2.

Function
REQ-004 The stage SHALL hold up to two entries: MAIN (head, drives outputs) and SKID (overflow); occupancy = number of valid entries.
REQ-005 State SHALL be EMPTY (0), ONE (MAIN valid), FULL (MAIN+SKID valid); encoding is free.
REQ-006 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE, 0 in FULL; no combinational path from out_ready to in_ready.
REQ-007 An input transfer SHALL occur when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-008 EMPTY: input transfer -> MAIN loaded, go ONE; otherwise stay.
REQ-009 ONE: input and output transfer -> MAIN reloaded from input, stay ONE; input only -> SKID loaded, go FULL; output only -> go EMPTY; neither -> stay.
REQ-010 FULL: output transfer -> MAIN loaded from SKID, go ONE; otherwise stay; input is never accepted.
REQ-011 Entries SHALL leave in arrival order; no entry may be lost or duplicated.
REQ-012 At capture, stored RegWrite SHALL be RegWriteM && (RdM != 0); x0 writes are suppressed.
REQ-013 Stored fields SHALL be the captured ResultSrc, ALUResult, ReadData, PCPlus4, Rd; ResultW SHALL be combinational from MAIN: 00 ALUResult, 01 ReadData, 10 PCPlus4, 11 all zeros.
REQ-014 out_valid SHALL be 1 exactly in ONE and FULL; RegWriteW SHALL equal MAIN RegWrite && out_valid.
REQ-015 Input-to-output latency SHALL be one cycle when ONE/EMPTY and downstream ready; throughput one entry per cycle with out_ready held 1.
REQ-016 flush=1 SHALL force state EMPTY next cycle, discarding MAIN, SKID and any same-cycle input; in_ready becomes 1 next cycle.
REQ-017 Simultaneous flush and output transfer: the output transfer is considered complete; nothing re-presented.
REQ-018 ResultSrc/data fields of invalid entries are don't-care, but RegWriteW SHALL be 0 whenever out_valid=0.

Reset
REQ-019 reset=0 at a rising edge SHALL force: state EMPTY, occupancy 0, out_valid 0, RegWriteW 0, in_ready 1, MAIN/SKID fields (RegWrite, ResultSrc, ALUResult, ReadData, PCPlus4, Rd) all zero, ResultW 0.
REQ-020 Reset SHALL take priority over flush and any transfer, including mid-operation in FULL.
REQ-021 The first input transfer SHALL be possible in the first cycle after reset returns to 1.

Verification
REQ-022 Streaming: out_ready=1, 4 back-to-back entries (ALUResultM=1..4, ResultSrcM=00, RdM=5) -> ResultW 1,2,3,4 on consecutive cycles, each one cycle after capture, occupancy never >1.
REQ-023 Backpressure: out_ready=0, send A(ReadDataM=0xAAAA_0000, ResultSrcM=01), B(PCPlus4M=0x104, ResultSrcM=10), C -> in_ready=0 after B, occupancy=2, C held upstream; then out_ready=1 -> ResultW 0xAAAA_0000, 0x104, C in order.
REQ-024 x0 suppression: RegWriteM=1, RdM=0 -> out_valid=1, RegWriteW=0; RdM=3 -> RegWriteW=1.
REQ-025 Flush in FULL with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1; flushed input never appears.
REQ-026 Reset mid-operation: FULL, drive reset=0 one cycle -> all outputs per REQ-019; ResultSrc=11 entry afterwards -> ResultW=0.
